roi_seed_issuer: RTL and testbench
==================================

Name: roi_seed_issuer

Overview:
- Consumer stage directly downstream of the read-only IV seed generator in the REW encryption path.
- Accepts one read-only path request (leaf, Gentry version).
- Drives the generator's start/enable strobes and captures each bucket's (bucket version, bucket ID) pair.
- Expands each bucket into ChunksPerBkt AES seed words and issues them to the AES front end over a valid/ready handshake; pulses Done after the last seed of the path.

Parameters:
ORAML, 10, tree depth; path has ORAML+1 buckets
AESEntropy, 64, bucket version / IV width
ChunksPerBkt, 4, AES blocks per bucket (>=1)
ChunkIdxWidth, 2, width of chunk index field; must satisfy 2^ChunkIdxWidth >= ChunksPerBkt
AESWidth, 128, seed word width; must satisfy ORAML+1+AESEntropy+ChunkIdxWidth <= AESWidth

Ports:
Clock  in  1  single clock
Reset  in  1  asynchronous, active-low reset
Start  in  1  request pulse; accepted only when Busy=0
Leaf  in  ORAML  leaf of the read-only path
Version  in  AESEntropy  Gentry version for the path
Busy  out  1  high from accepted Start through the Done cycle
Done  out  1  one-cycle pulse after the final seed handshake
GenStart  out  1  to generator ROStart
GenEnable  out  1  to generator Enable
GenLeaf  out  ORAML  to generator ROLeaf; registered copy of Leaf
GenVersion  out  AESEntropy  to generator GentryVersion; registered copy of Version
GenBV  in  AESEntropy  from generator ROIBV
GenBID  in  ORAML+1  from generator ROIBID
SeedValid  out  1  seed word valid
SeedReady  in  1  AES front end accepts
SeedData  out  AESWidth  seed word: {zero pad, BktID, BV, ChunkIdx}

Behaviour:
- Reset (async, Reset=0):
  - FSM enters IDLE.
  - Busy, Done, GenStart, GenEnable and SeedValid are 0.
  - SeedData, GenLeaf and GenVersion are 0.
  - Counters are 0.
  - Reset mid-path discards the path; no Done is produced.
- FSM states and transitions:
  - IDLE: on Start, register Leaf/Version into GenLeaf/GenVersion; go to LOAD.
  - LOAD: GenStart=1 for exactly 1 cycle; BktCnt=0; go to WAIT.
  - WAIT: 1 cycle, so generator outputs settle; go to CAPTURE.
  - CAPTURE:
    - Latch GenBV and GenBID into local registers; ChunkCnt=0.
    - If BktCnt<ORAML, GenEnable=1 for this cycle only, so the generator precomputes the next bucket while seeds issue.
    - Go to ISSUE.
  - ISSUE:
    - SeedValid=1; SeedData is registered and formed from the latched BID/BV and ChunkCnt.
    - On SeedValid&SeedReady with ChunkCnt<ChunksPerBkt-1: ChunkCnt++ and the next word appears the following cycle.
    - On the handshake of the last chunk: if BktCnt==ORAML go to DONE; else BktCnt++ and go to CAPTURE.
  - DONE: Done=1 for 1 cycle, SeedValid=0; go to IDLE.
- Issue timing: with SeedReady held high, throughput is one seed per cycle within a bucket plus 1 bubble (CAPTURE) per bucket.
- Start-to-first-SeedValid latency is 4 cycles.
- Handshake rules:
  - SeedValid, once raised, stays high and SeedData stays stable until SeedReady.
  - SeedValid never depends combinationally on SeedReady.
- Start handling:
  - Start while Busy=1 is ignored; no queueing.
  - Start in the Done cycle is ignored; Busy is still 1.
- GenStart and GenEnable are never asserted in the same cycle.
- GenEnable count per path is exactly ORAML.
- Counters do not wrap: ChunkCnt is held at its maximum by FSM exit, and BktCnt is never advanced past ORAML.
- Busy = (state != IDLE).

Optional Feature:
- Macro: ROI_SEED_PERF_EN.
- With the macro defined:
  - Adds output StallCycles, 16 bits.
  - Counts cycles with SeedValid&!SeedReady; saturates at 0xFFFF.
  - Cleared on accepted Start and on reset; holds its value after Done.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - FSM state encoding: IDLE, LOAD, WAIT, CAPTURE, ISSUE, DONE.
  - SeedData field offsets and widths: ChunkIdx LSBs, then BV, then BID.
  - Width-check constants.
- One natural sub-module: roi_seed_pack, the combinational formatter of {pad, BID, BV, ChunkIdx} into AESWidth. The FSM and counters stay in the top module.

Test Plan:
- Basic path (ORAML=3, ChunksPerBkt=2, SeedReady=1, Leaf=3'b101, Version=0x40, generator model attached):
  - Exactly 8 seeds, and first SeedValid 4 cycles after Start.
  - Seeds 0 and 1 carry BV=0x40 with ChunkIdx 0 and 1; each bucket's BID/BV match the model.
  - Done occurs 1 cycle after seed 7, and GenEnable pulses exactly 3 times.
- Backpressure: SeedReady=0 for 5 cycles on seed 3 -> SeedValid stays high and SeedData is unchanged; the sequence resumes with no loss or duplication; StallCycles=5 when ROI_SEED_PERF_EN is defined.
- Start while Busy: second Start mid-ISSUE with Version=0x99 -> ignored; all seeds carry the first path's values; one Done only.
- Reset mid-path: assert Reset low during bucket 2 ISSUE -> next cycle SeedValid=0, Busy=0, no Done; a new Start then produces a full 8-seed path.
- Back-to-back paths: Start in the cycle after Done -> accepted; GenStart pulses once; the second path's seeds use the new Leaf/Version.
- Single-chunk config (ChunksPerBkt=1, ORAML=2): 3 seeds, each with ChunkIdx=0; one CAPTURE bubble between each pair of seeds.

Source files
------------

// File: rtl/roi_seed_issuer_pkg.sv
// Shared definitions for the read-only IV seed issuer.
// Holds the FSM state encoding, the seed word field layout
// and the parameter legality checks.
package roi_seed_issuer_pkg;

    // Default configuration
    localparam int unsigned DEF_ORAML           = 10;
    localparam int unsigned DEF_AES_ENTROPY     = 64;
    localparam int unsigned DEF_CHUNKS_PER_BKT  = 4;
    localparam int unsigned DEF_CHUNK_IDX_WIDTH = 2;
    localparam int unsigned DEF_AES_WIDTH       = 128;

    // Width of the optional stall counter
    localparam int unsigned STALL_CNT_W = 16;

    // Issuer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Seed word layout: chunk index in the LSBs, then BV, then BID, zero pad on top
    localparam int unsigned CHUNK_LSB = 0;

    function automatic int unsigned bv_lsb(input int unsigned chunk_idx_w);
        return chunk_idx_w;
    endfunction

    function automatic int unsigned bid_lsb(input int unsigned chunk_idx_w,
                                            input int unsigned entropy_w);
        return chunk_idx_w + entropy_w;
    endfunction

    // Number of seed word bits actually carrying information
    function automatic int unsigned seed_used_bits(input int unsigned oraml,
                                                   input int unsigned entropy_w,
                                                   input int unsigned chunk_idx_w);
        return oraml + 1 + entropy_w + chunk_idx_w;
    endfunction

    // Legal configuration: non-empty tree, chunk index wide enough, fields fit the seed word
    function automatic bit cfg_ok(input int unsigned oraml,
                                  input int unsigned entropy_w,
                                  input int unsigned chunks_per_bkt,
                                  input int unsigned chunk_idx_w,
                                  input int unsigned aes_w);
        bit ok;
        ok = (oraml >= 1) && (chunks_per_bkt >= 1) && (chunk_idx_w >= 1)
             && ((64'd1 << chunk_idx_w) >= 64'(chunks_per_bkt))
             && (seed_used_bits(oraml, entropy_w, chunk_idx_w) <= aes_w);
        return ok;
    endfunction

endpackage

// File: rtl/roi_seed_issuer_pack.sv
// Combinational seed word formatter: {zero pad, BID, BV, ChunkIdx}.
module roi_seed_pack
    import roi_seed_issuer_pkg::*;
#(
    parameter int unsigned ORAML         = DEF_ORAML,
    parameter int unsigned AESEntropy    = DEF_AES_ENTROPY,
    parameter int unsigned ChunkIdxWidth = DEF_CHUNK_IDX_WIDTH,
    parameter int unsigned AESWidth      = DEF_AES_WIDTH
) (
    input  logic [ORAML:0]           bid,
    input  logic [AESEntropy-1:0]    bv,
    input  logic [ChunkIdxWidth-1:0] chunk_idx,
    output logic [AESWidth-1:0]      seed_word_c
);

    localparam int unsigned BvLsb  = bv_lsb(ChunkIdxWidth);
    localparam int unsigned BidLsb = bid_lsb(ChunkIdxWidth, AESEntropy);

    // Place each field at its fixed offset; unused upper bits stay zero
    always_comb begin
        seed_word_c                                = '0;
        seed_word_c[CHUNK_LSB +: ChunkIdxWidth]    = chunk_idx;
        seed_word_c[BvLsb +: AESEntropy]           = bv;
        seed_word_c[BidLsb +: ORAML + 1]           = bid;
    end

endmodule

// File: rtl/roi_seed_issuer.sv
// Read-only path seed issuer: sequences the IV seed generator over one
// path and expands every bucket into ChunksPerBkt AES seed words.
// Optional feature: define ROI_SEED_PERF_EN to add the StallCycles counter.
module roi_seed_issuer
    import roi_seed_issuer_pkg::*;
#(
    parameter int unsigned ORAML         = DEF_ORAML,
    parameter int unsigned AESEntropy    = DEF_AES_ENTROPY,
    parameter int unsigned ChunksPerBkt  = DEF_CHUNKS_PER_BKT,
    parameter int unsigned ChunkIdxWidth = DEF_CHUNK_IDX_WIDTH,
    parameter int unsigned AESWidth      = DEF_AES_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ORAML-1:0]      Leaf,
    input  logic [AESEntropy-1:0] Version,
    output logic                  Busy,
    output logic                  Done,
    output logic                  GenStart,
    output logic                  GenEnable,
    output logic [ORAML-1:0]      GenLeaf,
    output logic [AESEntropy-1:0] GenVersion,
    input  logic [AESEntropy-1:0] GenBV,
    input  logic [ORAML:0]        GenBID,
    output logic                  SeedValid,
    input  logic                  SeedReady,
    output logic [AESWidth-1:0]   SeedData
`ifdef ROI_SEED_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] StallCycles
`endif
);

    localparam int unsigned BktW = $clog2(ORAML + 1);

    if (!cfg_ok(ORAML, AESEntropy, ChunksPerBkt, ChunkIdxWidth, AESWidth)) begin : g_cfg_check
        $error("roi_seed_issuer: illegal parameter combination");
    end

    state_e                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      gen_start_q, gen_start_d;
    logic                      gen_enable_q, gen_enable_d;
    logic                      seed_valid_q, seed_valid_d;
    logic [ORAML-1:0]          gen_leaf_q, gen_leaf_d;
    logic [AESEntropy-1:0]     gen_version_q, gen_version_d;
    logic [ORAML:0]            bid_q, bid_d;
    logic [AESEntropy-1:0]     bv_q, bv_d;
    logic [ChunkIdxWidth-1:0]  chunk_q, chunk_d;
    logic [BktW-1:0]           bkt_q, bkt_d;
    logic [AESWidth-1:0]       seed_data_q, seed_data_d;
    logic [AESWidth-1:0]       seed_word_c;
    logic                      handshake_c;
    logic                      last_chunk_c;
    logic                      last_bkt_c;

    assign handshake_c  = seed_valid_q & SeedReady;
    assign last_chunk_c = (chunk_q == ChunkIdxWidth'(ChunksPerBkt - 1));
    assign last_bkt_c   = (bkt_q == BktW'(ORAML));

    // Seed word for the next-cycle BID/BV/chunk values
    roi_seed_pack #(
        .ORAML         (ORAML),
        .AESEntropy    (AESEntropy),
        .ChunkIdxWidth (ChunkIdxWidth),
        .AESWidth      (AESWidth)
    ) u_pack (
        .bid         (bid_d),
        .bv          (bv_d),
        .chunk_idx   (chunk_d),
        .seed_word_c (seed_word_c)
    );

    // Next state, path registers and registered output strobes
    always_comb begin
        state_d       = state_q;
        gen_leaf_d    = gen_leaf_q;
        gen_version_d = gen_version_q;
        bid_d         = bid_q;
        bv_d          = bv_q;
        chunk_d       = chunk_q;
        bkt_d         = bkt_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    gen_leaf_d    = Leaf;
                    gen_version_d = Version;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bkt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                bid_d   = GenBID;
                bv_d    = GenBV;
                chunk_d = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (handshake_c) begin
                    if (!last_chunk_c) begin
                        chunk_d = chunk_q + ChunkIdxWidth'(1);
                    end else if (last_bkt_c) begin
                        state_d = ST_DONE;
                    end else begin
                        bkt_d   = bkt_q + BktW'(1);
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes decoded from the next state so they line up with it after the edge
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        gen_start_d  = (state_d == ST_LOAD);
        // The last bucket has nothing left to precompute
        gen_enable_d = (state_d == ST_CAPTURE) && (bkt_d < BktW'(ORAML));
        seed_valid_d = (state_d == ST_ISSUE);
    end

    // Seed word register: reload while issuing, otherwise hold
    always_comb begin
        seed_data_d = seed_data_q;
        if (seed_valid_d) begin
            seed_data_d = seed_word_c;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            gen_start_q   <= 1'b0;
            gen_enable_q  <= 1'b0;
            seed_valid_q  <= 1'b0;
            gen_leaf_q    <= '0;
            gen_version_q <= '0;
            bid_q         <= '0;
            bv_q          <= '0;
            chunk_q       <= '0;
            bkt_q         <= '0;
            seed_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            gen_start_q   <= gen_start_d;
            gen_enable_q  <= gen_enable_d;
            seed_valid_q  <= seed_valid_d;
            gen_leaf_q    <= gen_leaf_d;
            gen_version_q <= gen_version_d;
            bid_q         <= bid_d;
            bv_q          <= bv_d;
            chunk_q       <= chunk_d;
            bkt_q         <= bkt_d;
            seed_data_q   <= seed_data_d;
        end
    end

`ifdef ROI_SEED_PERF_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles where a seed waits on the AES front end
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && Start) begin
            stall_d = '0;
        end else if (seed_valid_q && !SeedReady && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign StallCycles = stall_q;
`endif

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign GenStart   = gen_start_q;
    assign GenEnable  = gen_enable_q;
    assign GenLeaf    = gen_leaf_q;
    assign GenVersion = gen_version_q;
    assign SeedValid  = seed_valid_q;
    assign SeedData   = seed_data_q;

endmodule

// File: tb/tb_roi_seed_issuer.sv
// Testbench for roi_seed_issuer: two instances (ORAML=3/2 chunks and
// ORAML=2/1 chunk), each driven by a behavioural seed generator.
module tb_roi_seed_issuer;

    localparam int unsigned L0 = 3, C0 = 2, W0 = 1;
    localparam int unsigned L1 = 2, C1 = 1, W1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Instance 0 signals
    logic         start0, ready0, busy0, done0, gs0, ge0, sv0;
    logic [2:0]   leaf0, gleaf0;
    logic [63:0]  ver0, gver0;
    logic [63:0]  gbv0 = '0;
    logic [3:0]   gbid0 = '0;
    logic [127:0] sd0;
    logic [15:0]  stall0;
    // Instance 1 signals
    logic         start1, ready1, busy1, done1, gs1, ge1, sv1;
    logic [1:0]   leaf1, gleaf1;
    logic [63:0]  ver1, gver1;
    logic [63:0]  gbv1 = '0;
    logic [2:0]   gbid1 = '0;
    logic [127:0] sd1;
    logic [15:0]  stall1;

    roi_seed_issuer #(.ORAML(L0), .AESEntropy(64), .ChunksPerBkt(C0),
                      .ChunkIdxWidth(W0), .AESWidth(128)) u_dut0 (
        .Clock(clk), .Reset(rst_n), .Start(start0), .Leaf(leaf0), .Version(ver0),
        .Busy(busy0), .Done(done0), .GenStart(gs0), .GenEnable(ge0),
        .GenLeaf(gleaf0), .GenVersion(gver0), .GenBV(gbv0), .GenBID(gbid0),
        .SeedValid(sv0), .SeedReady(ready0), .SeedData(sd0)
`ifdef ROI_SEED_PERF_EN
        , .StallCycles(stall0)
`endif
    );

    roi_seed_issuer #(.ORAML(L1), .AESEntropy(64), .ChunksPerBkt(C1),
                      .ChunkIdxWidth(W1), .AESWidth(128)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .Start(start1), .Leaf(leaf1), .Version(ver1),
        .Busy(busy1), .Done(done1), .GenStart(gs1), .GenEnable(ge1),
        .GenLeaf(gleaf1), .GenVersion(gver1), .GenBV(gbv1), .GenBID(gbid1),
        .SeedValid(sv1), .SeedReady(ready1), .SeedData(sd1)
`ifdef ROI_SEED_PERF_EN
        , .StallCycles(stall1)
`endif
    );

`ifndef ROI_SEED_PERF_EN
    assign stall0 = '0;
    assign stall1 = '0;
`endif

    // Reference: bucket i of a path is heap node (1<<i) + (leaf >> (depth-i))
    function automatic int bid_of(int oraml, int leaf, int i);
        if (i < 0 || i > oraml) return 0;
        return (1 << i) + (leaf >> (oraml - i));
    endfunction

    // Reference: bucket version derived from the path version (bucket 0 = version)
    function automatic logic [63:0] bv_of(logic [63:0] v, int i);
        return v + 64'(i) * 64'h1000_0000_0000_0011;
    endfunction

    function automatic logic [127:0] word_of(int oraml, int ciw, int leaf,
                                             logic [63:0] v, int b, int c);
        logic [127:0] w;
        w = (128'(bid_of(oraml, leaf, b)) << (ciw + 64)) | (128'(bv_of(v, b)) << ciw) | 128'(c);
        return w;
    endfunction

    // Generator models: GenStart rewinds to the root, GenEnable steps one level, outputs registered
    int gidx0 = 0;
    int gidx1 = 0;
    always @(posedge clk) begin
        if (gs0) gidx0 <= 0; else if (ge0) gidx0 <= gidx0 + 1;
        gbv0  <= bv_of(gver0, gidx0);
        gbid0 <= 4'(bid_of(int'(L0), int'(gleaf0), gidx0));
        if (gs1) gidx1 <= 0; else if (ge1) gidx1 <= gidx1 + 1;
        gbv1  <= bv_of(gver1, gidx1);
        gbid1 <= 3'(bid_of(int'(L1), int'(gleaf1), gidx1));
    end

    // Monitors, sampled mid-cycle
    logic [127:0] seeds0[$];
    int           scyc0[$];
    logic [127:0] seeds1[$];
    int           scyc1[$];
    int done_cnt0, done_cyc0, gs_cnt0, ge_cnt0, first_v0, stall_m0, proto_err0;
    int done_cnt1, ge_cnt1, first_v1;
    logic         psv = 1'b0, prdy = 1'b1;
    logic [127:0] psd = '0;

    always @(negedge clk) begin
        if (rst_n && sv0 && ready0) begin seeds0.push_back(sd0); scyc0.push_back(cyc); end
        if (sv0 && first_v0 < 0) first_v0 = cyc;
        if (sv0 && !ready0) stall_m0 = stall_m0 + 1;
        if (done0) begin done_cnt0 = done_cnt0 + 1; done_cyc0 = cyc; end
        if (gs0) gs_cnt0 = gs_cnt0 + 1;
        if (ge0) ge_cnt0 = ge_cnt0 + 1;
        if (gs0 && ge0) proto_err0 = proto_err0 + 1;
        if (rst_n && psv && !prdy && (!sv0 || sd0 !== psd)) proto_err0 = proto_err0 + 1;
        psv = sv0; prdy = ready0; psd = sd0;
        if (rst_n && sv1 && ready1) begin seeds1.push_back(sd1); scyc1.push_back(cyc); end
        if (sv1 && first_v1 < 0) first_v1 = cyc;
        if (done1) done_cnt1 = done_cnt1 + 1;
        if (ge1) ge_cnt1 = ge_cnt1 + 1;
    end

    task automatic clr0();
        seeds0.delete(); scyc0.delete();
        done_cnt0 = 0; done_cyc0 = -1; gs_cnt0 = 0; ge_cnt0 = 0; first_v0 = -1; stall_m0 = 0;
    endtask

    task automatic clr1();
        seeds1.delete(); scyc1.delete();
        done_cnt1 = 0; ge_cnt1 = 0; first_v1 = -1;
    endtask

    task automatic start_path0(input logic [2:0] l, input logic [63:0] v, output int st);
        @(posedge clk); #1;
        leaf0 = l; ver0 = v; start0 = 1'b1; st = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    // Wait for Done; mode 1 drives random SeedReady, otherwise SeedReady=1
    task automatic wait_done0(input int max, input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            ready0 = (mode == 1) ? ($urandom_range(0, 99) < 70) : 1'b1;
        end
        ready0 = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done0); end
        n_tests++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sv0); end
        n_tests++; if ({gs0, ge0} !== 2'b00) begin n_fail++; $display("FAIL reset_gen_strobes: got %b expected 00", {gs0, ge0}); end
        n_tests++; if (sd0 !== 128'd0) begin n_fail++; $display("FAIL reset_seed_data: got %h expected 0", sd0); end
        n_tests++; if ({gleaf0, gver0} !== 67'd0) begin n_fail++; $display("FAIL reset_gen_path: got %h expected 0", {gleaf0, gver0}); end
        n_tests++; if ({busy1, sv1} !== 2'b00) begin n_fail++; $display("FAIL reset_dut1: got %b expected 00", {busy1, sv1}); end
        n_tests++; if (stall0 !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall0); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy0); end
        clr0(); clr1();
    endtask

    task automatic test_basic();
        logic [127:0] exp[$];
        int st, n;
        bit ok;
        clr0(); ready0 = 1'b1;
        for (int b = 0; b <= int'(L0); b++)
            for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, 5, 64'h40, b, c));
        start_path0(3'b101, 64'h40, st);
        wait_done0(200, 0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_done: got timeout expected Done"); end
        @(posedge clk); #1;
        n_tests++; if (seeds0.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", seeds0.size()); end
        n_tests++; if (first_v0 - st != 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", first_v0 - st); end
        n = (seeds0.size() < exp.size()) ? seeds0.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL basic_seed%0d: got %h expected %h", i, seeds0[i], exp[i]); end
        end
        if (seeds0.size() == 8) begin
            n_tests++; if (done_cyc0 != scyc0[7] + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc0, scyc0[7] + 1); end
            n_tests++; if (scyc0[7] - scyc0[0] != 10) begin n_fail++; $display("FAIL basic_throughput: got %0d expected 10", scyc0[7] - scyc0[0]); end
        end
        n_tests++; if (ge_cnt0 != 3) begin n_fail++; $display("FAIL basic_gen_enable: got %0d expected 3", ge_cnt0); end
        n_tests++; if (gs_cnt0 != 1 || done_cnt0 != 1) begin n_fail++; $display("FAIL basic_pulses: got gs=%0d done=%0d expected 1/1", gs_cnt0, done_cnt0); end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp[$];
        logic [2:0]   l;
        logic [63:0]  v;
        int st;
        bit ok;
        l = 3'($urandom); v = {$urandom, $urandom};
        clr0(); ready0 = 1'b1;
        for (int b = 0; b <= int'(L0); b++)
            for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, int'(l), v, b, c));
        start_path0(l, v, st);
        for (int i = 0; i < 100 && seeds0.size() < 3; i++) begin @(posedge clk); #1; end
        n_tests++; if (seeds0.size() != 3) begin n_fail++; $display("FAIL bp_reach: got %0d seeds expected 3", seeds0.size()); end
        ready0 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_tests++; if (sv0 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", sv0); end
            n_tests++; if (sd0 !== exp[3]) begin n_fail++; $display("FAIL bp_data_held: got %h expected %h", sd0, exp[3]); end
            @(posedge clk); #1;
        end
        ready0 = 1'b1;
        wait_done0(200, 0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_done: got timeout expected Done"); end
        @(posedge clk); #1;
        n_tests++; if (seeds0.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", seeds0.size()); end
        for (int i = 0; i < 8 && i < seeds0.size(); i++) begin
            n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL bp_seed%0d: got %h expected %h", i, seeds0[i], exp[i]); end
        end
`ifdef ROI_SEED_PERF_EN
        n_tests++; if (stall0 !== 16'd5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall0); end
`endif
    endtask

    task automatic test_start_busy();
        logic [127:0] exp[$];
        int st;
        bit ok;
        clr0(); ready0 = 1'b1;
        for (int b = 0; b <= int'(L0); b++)
            for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, 3, 64'h40, b, c));
        start_path0(3'b011, 64'h40, st);
        for (int i = 0; i < 100 && seeds0.size() < 3; i++) begin @(posedge clk); #1; end
        leaf0 = 3'b110; ver0 = 64'h99; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0(200, 0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_done: got timeout expected Done"); end
        ver0 = 64'h77; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got %b expected 0", busy0); end
        n_tests++; if (seeds0.size() != 8) begin n_fail++; $display("FAIL busy_count: got %0d expected 8", seeds0.size()); end
        for (int i = 0; i < 8 && i < seeds0.size(); i++) begin
            n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL busy_seed%0d: got %h expected %h", i, seeds0[i], exp[i]); end
        end
        n_tests++; if (done_cnt0 != 1 || gs_cnt0 != 1) begin n_fail++; $display("FAIL busy_pulses: got done=%0d gs=%0d expected 1/1", done_cnt0, gs_cnt0); end
        n_tests++; if (gver0 !== 64'h40) begin n_fail++; $display("FAIL busy_gen_version: got %h expected 40", gver0); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] exp[$];
        logic [2:0]   l;
        logic [63:0]  v;
        int st;
        bit ok;
        clr0(); ready0 = 1'b1;
        start_path0(3'($urandom), {$urandom, $urandom}, st);
        for (int i = 0; i < 100 && !(seeds0.size() == 4 && sv0); i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({sv0, busy0} !== 2'b00) begin n_fail++; $display("FAIL rmid_outputs: got valid/busy=%b expected 00", {sv0, busy0}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        n_tests++; if (done_cnt0 != 0 || seeds0.size() != 4) begin n_fail++; $display("FAIL rmid_discard: got done=%0d seeds=%0d expected 0/4", done_cnt0, seeds0.size()); end
        l = 3'($urandom); v = {$urandom, $urandom};
        for (int b = 0; b <= int'(L0); b++)
            for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, int'(l), v, b, c));
        clr0();
        start_path0(l, v, st);
        wait_done0(200, 0, ok);
        @(posedge clk); #1;
        n_tests++; if (!ok || seeds0.size() != 8) begin n_fail++; $display("FAIL rmid_restart: got done=%0d seeds=%0d expected 1/8", ok, seeds0.size()); end
        for (int i = 0; i < 8 && i < seeds0.size(); i++) begin
            n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL rmid_seed%0d: got %h expected %h", i, seeds0[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp[$];
        logic [2:0]   lb;
        logic [63:0]  vb;
        int st;
        bit ok;
        clr0(); ready0 = 1'b1;
        start_path0(3'($urandom), {$urandom, $urandom}, st);
        wait_done0(200, 0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_first_done: got timeout expected Done"); end
        @(posedge clk); #1;
        n_tests++; if (seeds0.size() != 8) begin n_fail++; $display("FAIL b2b_first_count: got %0d expected 8", seeds0.size()); end
        lb = 3'($urandom); vb = {$urandom, $urandom};
        for (int b = 0; b <= int'(L0); b++)
            for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, int'(lb), vb, b, c));
        clr0();
        leaf0 = lb; ver0 = vb; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b expected 1", busy0); end
        wait_done0(200, 0, ok);
        @(posedge clk); #1;
        n_tests++; if (!ok || gs_cnt0 != 1) begin n_fail++; $display("FAIL b2b_gen_start: got done=%0d gs=%0d expected 1/1", ok, gs_cnt0); end
        n_tests++; if ({gleaf0, gver0} !== {lb, vb}) begin n_fail++; $display("FAIL b2b_gen_path: got %h expected %h", {gleaf0, gver0}, {lb, vb}); end
        n_tests++; if (seeds0.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", seeds0.size()); end
        for (int i = 0; i < 8 && i < seeds0.size(); i++) begin
            n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_seed%0d: got %h expected %h", i, seeds0[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [127:0] exp[$];
        logic [2:0]   l;
        logic [63:0]  v;
        int st;
        bit ok;
        for (int p = 0; p < 4; p++) begin
            l = 3'($urandom); v = {$urandom, $urandom};
            exp.delete();
            for (int b = 0; b <= int'(L0); b++)
                for (int c = 0; c < int'(C0); c++) exp.push_back(word_of(L0, W0, int'(l), v, b, c));
            clr0();
            start_path0(l, v, st);
            wait_done0(400, 1, ok);
            @(posedge clk); #1;
            n_tests++; if (!ok || seeds0.size() != 8) begin n_fail++; $display("FAIL rand%0d_count: got done=%0d seeds=%0d expected 1/8", p, ok, seeds0.size()); end
            for (int i = 0; i < 8 && i < seeds0.size(); i++) begin
                n_tests++; if (seeds0[i] !== exp[i]) begin n_fail++; $display("FAIL rand%0d_seed%0d: got %h expected %h", p, i, seeds0[i], exp[i]); end
            end
            n_tests++; if (ge_cnt0 != 3 || done_cnt0 != 1) begin n_fail++; $display("FAIL rand%0d_pulses: got ge=%0d done=%0d expected 3/1", p, ge_cnt0, done_cnt0); end
`ifdef ROI_SEED_PERF_EN
            n_tests++; if (stall0 !== 16'(stall_m0)) begin n_fail++; $display("FAIL rand%0d_stall: got %0d expected %0d", p, stall0, stall_m0); end
`endif
        end
    endtask

    task automatic test_single_chunk();
        logic [127:0] exp[$];
        logic [1:0]   l;
        logic [63:0]  v;
        int st;
        l = 2'($urandom); v = {$urandom, $urandom};
        for (int b = 0; b <= int'(L1); b++) exp.push_back(word_of(L1, W1, int'(l), v, b, 0));
        clr1(); ready1 = 1'b1;
        @(posedge clk); #1;
        leaf1 = l; ver1 = v; start1 = 1'b1; st = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 100 && done_cnt1 == 0; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        n_tests++; if (done_cnt1 != 1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL single_done: got done=%0d busy=%b expected 1/0", done_cnt1, busy1); end
        n_tests++; if (seeds1.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", seeds1.size()); end
        n_tests++; if (first_v1 - st != 4) begin n_fail++; $display("FAIL single_latency: got %0d expected 4", first_v1 - st); end
        for (int i = 0; i < 3 && i < seeds1.size(); i++) begin
            n_tests++; if (seeds1[i] !== exp[i]) begin n_fail++; $display("FAIL single_seed%0d: got %h expected %h", i, seeds1[i], exp[i]); end
        end
        for (int i = 1; i < 3 && i < scyc1.size(); i++) begin
            n_tests++; if (scyc1[i] - scyc1[i-1] != 2) begin n_fail++; $display("FAIL single_bubble%0d: got gap %0d expected 2", i, scyc1[i] - scyc1[i-1]); end
        end
        n_tests++; if (ge_cnt1 != 2) begin n_fail++; $display("FAIL single_gen_enable: got %0d expected 2", ge_cnt1); end
        n_tests++; if (stall1 !== 16'd0) begin n_fail++; $display("FAIL single_stall: got %0d expected 0", stall1); end
    endtask

    task automatic test_protocol();
        n_tests++; if (proto_err0 != 0) begin n_fail++; $display("FAIL protocol: got %0d violations expected 0", proto_err0); end
    endtask

    initial begin
        start0 = 1'b0; leaf0 = '0; ver0 = '0; ready0 = 1'b1;
        start1 = 1'b0; leaf1 = '0; ver1 = '0; ready1 = 1'b1;
        proto_err0 = 0;
        clr0(); clr1();
        test_reset();
        test_basic();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_single_chunk();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1);
    end

endmodule
